// File: rtl/ad7864_pkg.sv
// Shared types and constants for the AD7864 read sequencer: FSM encoding,
// output word layout and the data-word packing helper.
package ad7864_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } state_e;

  localparam int ADC_W    = 12;
  localparam int WORD_W   = 16;
  localparam int CH_MSB   = 15;
  localparam int CH_LSB   = 14;
  localparam int DATA_MSB = 11;

  // {ch[1:0], 2'b00, sample[11:0]}
  function automatic logic [WORD_W-1:0] pack_word(input logic [1:0] ch,
                                                  input logic [ADC_W-1:0] d);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[CH_MSB:CH_LSB]   = ch;
    w[DATA_MSB:0]      = d;
    return w;
  endfunction
endpackage

// File: rtl/ad7864_rd_seq_if.sv
// Push/pop bus between the read sequencer (master) and its output FIFO (slave).
interface ad7864_rd_seq_if;
  import ad7864_pkg::*;

  logic              push;
  logic [WORD_W-1:0] wdata;
  logic              pop;
  logic              valid;
  logic [WORD_W-1:0] rdata;
  logic              ovf_evt;

  modport master (output push, wdata, pop, input valid, rdata, ovf_evt);
  modport slave  (input push, wdata, pop, output valid, rdata, ovf_evt);
endinterface

// File: rtl/ad7864_sfifo.sv
// Show-ahead synchronous FIFO with registered valid/head outputs; head reads 0 when empty.
module ad7864_sfifo
  import ad7864_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic             clkin,
  input logic             rst_bar,
  ad7864_rd_seq_if.slave  bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              valid_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              pop_acc, push_acc;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_acc  = bus.pop && valid_q;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the push
    push_acc = bus.push && ((cnt_q != FULL) || pop_acc);
    wr_ptr_d = push_acc ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    if (cnt_d == '0)                            rdata_d = '0;
    else if (push_acc && (wr_ptr_q == rd_ptr_d)) rdata_d = bus.wdata;
    else                                        rdata_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clkin) begin
    if (push_acc) mem_q[wr_ptr_q] <= bus.wdata;
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= (cnt_d != '0);
      rdata_q  <= rdata_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.rdata   = rdata_q;
  assign bus.ovf_evt = bus.push && !push_acc;
endmodule

// File: rtl/ad7864_rd_seq.sv
// AD7864 read sequencer: waits for BUSY low after a start pulse, strobes RD for
// NCH channels under one CS window and queues tagged samples for the DSP.
module ad7864_rd_seq
  import ad7864_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int RD_LOW     = 2,
  parameter int RD_HIGH    = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int BUSY_TO    = 255
) (
  input  logic              clkin,
  input  logic              rst_bar,
  input  logic              db_rdy,
  input  logic              ad_busy,
  input  logic [ADC_W-1:0]  ad_db,
  output logic              ad_cs_bar,
  output logic              ad_rd_bar,
  input  logic              dsp_rd,
  output logic              dsp_valid,
  output logic [WORD_W-1:0] dsp_data,
  output logic              ovf,
  output logic              seq_err,
  input  logic              flag_clr
);
  localparam int MAXC = (BUSY_TO > RD_LOW) ? ((BUSY_TO > RD_HIGH) ? BUSY_TO : RD_HIGH)
                                           : ((RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH);
  localparam int CW   = $clog2(MAXC + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic          cs_bar_q, cs_bar_d, rd_bar_q, rd_bar_d;
  logic          ovf_q, seq_err_q;
  logic          push, to_evt, seq_evt;

  ad7864_rd_seq_if fifo_bus ();

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      cs_bar_q  <= 1'b1;
      rd_bar_q  <= 1'b1;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      cs_bar_q  <= cs_bar_d;
      rd_bar_q  <= rd_bar_d;
      // a set event on the clearing edge wins
      ovf_q     <= fifo_bus.ovf_evt | (ovf_q & ~flag_clr);
      seq_err_q <= seq_evt | (seq_err_q & ~flag_clr);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    to_evt  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (db_rdy) begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        if (!ad_busy) begin
          state_d = ST_RD_LO;
          ch_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(BUSY_TO-1)) begin
          state_d = ST_IDLE;
          to_evt  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD_LO: begin
        if (cnt_q == CW'(RD_LOW-1)) begin
          state_d = ST_RD_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD_HI: begin
        if (cnt_q == CW'(RD_HIGH-1)) begin
          cnt_d = '0;
          if (ch_q == 2'(NCH-1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_LO;
            ch_d    = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // strobes are decoded from the next state so the pins come straight off flops
  always_comb begin
    push     = (state_q == ST_RD_LO) && (cnt_q == CW'(RD_LOW-1));
    cs_bar_d = !((state_d == ST_RD_LO) || (state_d == ST_RD_HI));
    rd_bar_d = (state_d != ST_RD_LO);
    seq_evt  = to_evt || (db_rdy && (state_q != ST_IDLE));
  end

  assign fifo_bus.push  = push;
  assign fifo_bus.wdata = pack_word(ch_q, ad_db);
  assign fifo_bus.pop   = dsp_rd;

  ad7864_sfifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clkin   (clkin),
    .rst_bar (rst_bar),
    .bus     (fifo_bus)
  );

  assign ad_cs_bar = cs_bar_q;
  assign ad_rd_bar = rd_bar_q;
  assign dsp_valid = fifo_bus.valid;
  assign dsp_data  = fifo_bus.rdata;
  assign ovf       = ovf_q;
  assign seq_err   = seq_err_q;
endmodule

// File: tb/tb_ad7864_rd_seq.sv
// Bench for ad7864_rd_seq: ADC responder feeds samples and queues the expected
// words; the DSP side pops and compares against the queue.
module tb_ad7864_rd_seq;
  import ad7864_pkg::*;

  localparam int NCH = 4, RD_LOW = 2, RD_HIGH = 1, DEPTH = 8, BUSY_TO = 255;

  logic        clkin    = 1'b0;
  logic        rst_bar  = 1'b0;
  logic        db_rdy   = 1'b0;
  logic        ad_busy  = 1'b0;
  logic        flag_clr = 1'b0;
  logic [11:0] ad_db    = '0;
  logic        ad_cs_bar, ad_rd_bar, ovf, seq_err;

  ad7864_rd_seq_if dsp ();

  always #5 clkin = ~clkin;

  ad7864_rd_seq #(
    .NCH(NCH), .RD_LOW(RD_LOW), .RD_HIGH(RD_HIGH), .FIFO_DEPTH(DEPTH), .BUSY_TO(BUSY_TO)
  ) dut (
    .clkin     (clkin),
    .rst_bar   (rst_bar),
    .db_rdy    (db_rdy),
    .ad_busy   (ad_busy),
    .ad_db     (ad_db),
    .ad_cs_bar (ad_cs_bar),
    .ad_rd_bar (ad_rd_bar),
    .dsp_rd    (dsp.pop),
    .dsp_valid (dsp.valid),
    .dsp_data  (dsp.rdata),
    .ovf       (ovf),
    .seq_err   (seq_err),
    .flag_clr  (flag_clr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ADC model: new sample on each RD fall, expected word queued in channel order
  logic [11:0] base_tbl [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic [15:0] exp_q [$];
  int rd_falls = 0;
  int ch_mdl   = 0;

  always @(negedge ad_rd_bar) begin : resp
    logic [11:0] d;
    if (rst_bar) begin
      d     = base_tbl[rd_falls % 4] ^ 12'((rd_falls / 4) * 12'h111);
      ad_db = d;
      exp_q.push_back({2'(ch_mdl), 2'b00, d});
      ch_mdl++;
      rd_falls++;
    end
  end

  // strobe shape monitor
  int lo_run = 0;
  int cs_run = 0;
  always @(negedge clkin) begin
    if (!rst_bar) begin
      lo_run = 0;
      cs_run = 0;
    end else begin
      if (!ad_rd_bar) begin
        lo_run++;
        chk("cs_low_with_rd", ad_cs_bar, 0);
      end else if (lo_run != 0) begin
        chk("rd_low_width", lo_run, RD_LOW);
        lo_run = 0;
      end
      if (!ad_cs_bar) cs_run++;
      else if (cs_run != 0) begin
        chk("cs_low_width", cs_run, NCH * (RD_LOW + RD_HIGH));
        cs_run = 0;
      end
    end
  end

  task automatic start_frame(input int wait_cyc);
    @(negedge clkin);
    ch_mdl  = 0;
    db_rdy  = 1'b1;
    ad_busy = 1'b1;
    @(negedge clkin);
    db_rdy = 1'b0;
    repeat (wait_cyc - 1) @(negedge clkin);
    ad_busy = 1'b0;
  endtask

  task automatic end_frame();
    int n = 0;
    while (ad_cs_bar && n < 300) begin @(negedge clkin); n++; end
    while (!ad_cs_bar && n < 300) begin @(negedge clkin); n++; end
    chk("frame_end_in_time", (n < 300), 1);
    @(negedge clkin);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (rd_falls < target && n < 300) begin @(negedge clkin); n++; end
    chk("rd_fall_seen", (rd_falls >= target), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (n < 20) begin
      @(negedge clkin);
      dsp.pop = 1'b0;
      if (!dsp.valid) break;
      if (exp_q.size() == 0) chk("extra_word", dsp.rdata, 32'hFFFF_FFFF);
      else                   chk("dsp_data", dsp.rdata, exp_q.pop_front());
      dsp.pop = 1'b1;
      n++;
    end
    dsp.pop = 1'b0;
    chk("words_left", exp_q.size(), 0);
    chk("empty_data_zero", dsp.rdata, 0);
  endtask

  task automatic clear_flags();
    @(negedge clkin);
    flag_clr = 1'b1;
    @(negedge clkin);
    flag_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    dsp.pop     = 1'b0;
    dsp.push    = 1'b0;
    dsp.wdata   = '0;
    dsp.ovf_evt = 1'b0;

    repeat (3) @(negedge clkin);
    chk("rst_cs_bar", ad_cs_bar, 1);
    chk("rst_rd_bar", ad_rd_bar, 1);
    chk("rst_valid", dsp.valid, 0);
    chk("rst_data", dsp.rdata, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_seq_err", seq_err, 0);
    rst_bar = 1'b1;

    // nominal frame: four tagged words, channel 0 first
    start_frame(10);
    end_frame();
    chk("t030_pulses", rd_falls, 4);
    chk("t030_valid", dsp.valid, 1);
    chk("t030_ovf", ovf, 0);
    chk("t030_seq_err", seq_err, 0);
    drain();

    // BUSY stuck high: timeout, no strobes
    base = rd_falls;
    @(negedge clkin);
    db_rdy  = 1'b1;
    ad_busy = 1'b1;
    @(negedge clkin);
    db_rdy = 1'b0;
    repeat (200) @(negedge clkin);
    chk("t031_no_err_early", seq_err, 0);
    repeat (80) @(negedge clkin);
    chk("t031_seq_err", seq_err, 1);
    chk("t031_no_pulse", rd_falls, base);
    chk("t031_empty", dsp.valid, 0);
    clear_flags();
    chk("t031_clr", seq_err, 0);

    // three frames into depth 8: last four words dropped
    repeat (3) begin start_frame(3); end_frame(); end
    chk("t032_ovf", ovf, 1);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    drain();
    clear_flags();
    chk("t032_ovf_clr", ovf, 0);

    // full FIFO, pop exactly on each capture edge
    repeat (2) begin start_frame(3); end_frame(); end
    chk("t033_full_valid", dsp.valid, 1);
    start_frame(3);
    base = rd_falls;
    for (int k = 0; k < NCH; k++) begin
      wait_falls(base + k + 1);
      repeat (RD_LOW - 1) @(posedge clkin);
      #1;
      chk("t033_head", dsp.rdata, exp_q.pop_front());
      dsp.pop = 1'b1;
      @(posedge clkin);
      #1;
      dsp.pop = 1'b0;
    end
    end_frame();
    chk("t033_no_ovf", ovf, 0);
    drain();

    // start pulse during channel 1 read
    start_frame(3);
    base = rd_falls;
    wait_falls(base + 2);
    db_rdy = 1'b1;
    @(negedge clkin);
    db_rdy = 1'b0;
    end_frame();
    chk("t034_seq_err", seq_err, 1);
    chk("t034_pulses", rd_falls - base, 4);
    drain();
    clear_flags();

    // reset during channel 2 read
    start_frame(3);
    base = rd_falls;
    wait_falls(base + 3);
    @(posedge clkin);
    #1;
    rst_bar = 1'b0;
    #1;
    chk("t035_rd_bar", ad_rd_bar, 1);
    chk("t035_cs_bar", ad_cs_bar, 1);
    chk("t035_valid", dsp.valid, 0);
    chk("t035_data", dsp.rdata, 0);
    @(negedge clkin);
    #2;
    rst_bar = 1'b1;
    exp_q.delete();
    ad_busy = 1'b1;
    @(negedge clkin);
    chk("t035_post_valid", dsp.valid, 0);
    chk("t035_post_seq_err", seq_err, 0);

    // recovery frame
    start_frame(4);
    end_frame();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
